// File: rtl/dco_tune_pkg.sv
// Shared state encoding and default geometry for the DCO cap-bank tuning controller.
package dco_tune_pkg;

    localparam int unsigned DEF_COARSE_W   = 4;
    localparam int unsigned DEF_FINE_W     = 6;
    localparam int unsigned DEF_SETTLE_CYC = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_COARSE = 3'd1,
        ST_FINE   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_TRACK  = 3'd4
    } tune_state_e;

endpackage

// File: rtl/dco_therm_enc.sv
// Binary-to-thermometer encoder for the unit-element coarse cap bank.
module dco_therm_enc #(
    parameter int unsigned BIN_W = 4
) (
    input  logic [BIN_W-1:0]      bin,
    output logic [(2**BIN_W)-2:0] therm
);

    always_comb begin
        therm = '0;
        for (int unsigned i = 0; i < (2**BIN_W) - 1; i++) begin
            therm[i] = (32'(bin) > i);
        end
    end

endmodule

// File: rtl/dco_tune_ctrl.sv
// DCO tuning FSM: coarse search, fine search with carry into coarse, settle blanking
// after every code change, and lock tracking.
module dco_tune_ctrl
    import dco_tune_pkg::*;
#(
    parameter int unsigned COARSE_W   = DEF_COARSE_W,
    parameter int unsigned FINE_W     = DEF_FINE_W,
    parameter int unsigned SETTLE_CYC = DEF_SETTLE_CYC
) (
    input  logic                               ref_clk,
    input  logic                               reset,
    input  logic                               enable,
    input  logic                               freq_update,
    input  logic                               freq_incr_decr,
    input  logic                               fll_locked,
    output logic [(2**COARSE_W)-1+FINE_W-1:0]  sw,
    output logic [2:0]                         tune_state,
    output logic                               tune_locked,
    output logic                               code_sat
);

    localparam int unsigned NSW   = (2**COARSE_W) - 1;
    localparam int unsigned CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    localparam logic [COARSE_W-1:0] COARSE_MID  = COARSE_W'(2**(COARSE_W-1));
    localparam logic [FINE_W-1:0]   FINE_MID    = FINE_W'(2**(FINE_W-1));
    localparam logic [FINE_W-1:0]   FINE_MID_M1 = FINE_W'(2**(FINE_W-1) - 1);
    localparam logic [NSW-1:0]      THERM_MID   = ~({NSW{1'b1}} << (2**(COARSE_W-1)));
    localparam logic [CNT_W-1:0]    SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

    tune_state_e         state;
    tune_state_e         target;
    logic [COARSE_W-1:0] coarse;
    logic [FINE_W-1:0]   fine;
    logic [CNT_W-1:0]    settle_cnt;
    logic                dir_valid;
    logic                dir_last;
    logic [NSW-1:0]      therm;

    dco_therm_enc #(.BIN_W(COARSE_W)) u_therm (
        .bin   (coarse),
        .therm (therm)
    );

    // freq_incr_decr=1 raises frequency, i.e. removes capacitance (code decrements).
    always_ff @(posedge ref_clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            target     <= ST_COARSE;
            coarse     <= COARSE_MID;
            fine       <= FINE_MID;
            settle_cnt <= '0;
            dir_valid  <= 1'b0;
            dir_last   <= 1'b0;
        end else if (!enable) begin
            state      <= ST_IDLE;
            settle_cnt <= '0;
            dir_valid  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state     <= ST_COARSE;
                    dir_valid <= 1'b0;
                end
                ST_COARSE: begin
                    if (freq_update) begin
                        state      <= ST_SETTLE;
                        settle_cnt <= '0;
                        if (dir_valid && (freq_incr_decr != dir_last)) begin
                            fine   <= FINE_MID;
                            target <= ST_FINE;
                        end else begin
                            dir_valid <= 1'b1;
                            dir_last  <= freq_incr_decr;
                            target    <= ST_COARSE;
                            if (freq_incr_decr) begin
                                if (coarse != '0) coarse <= coarse - COARSE_W'(1);
                            end else begin
                                if (coarse != '1) coarse <= coarse + COARSE_W'(1);
                            end
                        end
                    end
                end
                ST_FINE: begin
                    if (freq_update) begin
                        state      <= ST_SETTLE;
                        settle_cnt <= '0;
                        target     <= ST_FINE;
                        // Fine wrap re-centres fine and carries into coarse; full code saturates.
                        if (!freq_incr_decr) begin
                            if (fine != '1) begin
                                fine <= fine + FINE_W'(1);
                            end else if (coarse != '1) begin
                                fine   <= FINE_MID;
                                coarse <= coarse + COARSE_W'(1);
                            end
                        end else begin
                            if (fine != '0) begin
                                fine <= fine - FINE_W'(1);
                            end else if (coarse != '0) begin
                                fine   <= FINE_MID_M1;
                                coarse <= coarse - COARSE_W'(1);
                            end
                        end
                    end else if (fll_locked) begin
                        state <= ST_TRACK;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state      <= target;
                        settle_cnt <= '0;
                    end else begin
                        settle_cnt <= settle_cnt + CNT_W'(1);
                    end
                end
                ST_TRACK: begin
                    if (!fll_locked) state <= ST_FINE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge ref_clk or negedge reset) begin
        if (!reset) begin
            sw <= {THERM_MID, FINE_MID};
        end else begin
            sw <= {therm, fine};
        end
    end

    assign tune_state  = state;
    assign tune_locked = (state == ST_TRACK);
    assign code_sat    = ((coarse == '0) && (fine == '0)) || ((coarse == '1) && (fine == '1));

endmodule

// File: tb/tb_dco_tune_ctrl.sv
// Directed + randomized bench for dco_tune_ctrl against an integer-code reference model.
module tb_dco_tune_ctrl;

    localparam int SC       = 16;
    localparam int CODE_MAX = 15 * 64 + 63;
    localparam int CODE_MID = 8 * 64 + 32;
    localparam int S_IDLE   = 0;
    localparam int S_COARSE = 1;
    localparam int S_FINE   = 2;
    localparam int S_SETTLE = 3;
    localparam int S_TRACK  = 4;
    localparam logic [20:0] SW_MID = {15'h00FF, 6'h20};

    logic        ref_clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        freq_update = 1'b0;
    logic        freq_incr_decr = 1'b0;
    logic        fll_locked = 1'b0;
    logic [20:0] sw;
    logic [2:0]  tune_state;
    logic        tune_locked;
    logic        code_sat;

    int checks = 0;
    int errors = 0;

    int m_state, m_target, m_code, m_sw_code, m_remain;
    bit m_dir_valid, m_dir;

    dco_tune_ctrl #(.COARSE_W(4), .FINE_W(6), .SETTLE_CYC(SC)) dut (
        .ref_clk        (ref_clk),
        .reset          (reset),
        .enable         (enable),
        .freq_update    (freq_update),
        .freq_incr_decr (freq_incr_decr),
        .fll_locked     (fll_locked),
        .sw             (sw),
        .tune_state     (tune_state),
        .tune_locked    (tune_locked),
        .code_sat       (code_sat)
    );

    always #5 ref_clk = ~ref_clk;

    function automatic logic [20:0] sw_of(input int code);
        int c = code / 64;
        int f = code % 64;
        logic [14:0] th = 15'((1 << c) - 1);
        logic [5:0]  fb = 6'(f);
        return {th, fb};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state     = S_IDLE;
        m_target    = S_COARSE;
        m_code      = CODE_MID;
        m_sw_code   = CODE_MID;
        m_remain    = 0;
        m_dir_valid = 0;
        m_dir       = 0;
    endtask

    // One rising edge of the reference: code is an integer 0..1023 = coarse*64+fine.
    task automatic model_edge();
        int c = m_code / 64;
        int f = m_code % 64;
        m_sw_code = m_code;
        if (!enable) begin
            m_state     = S_IDLE;
            m_remain    = 0;
            m_dir_valid = 0;
            return;
        end
        case (m_state)
            S_IDLE: begin
                m_state     = S_COARSE;
                m_dir_valid = 0;
            end
            S_COARSE: if (freq_update) begin
                if (m_dir_valid && (freq_incr_decr != m_dir)) begin
                    m_code   = c * 64 + 32;
                    m_target = S_FINE;
                end else begin
                    m_dir_valid = 1;
                    m_dir       = freq_incr_decr;
                    m_target    = S_COARSE;
                    if (freq_incr_decr && c > 0) m_code -= 64;
                    else if (!freq_incr_decr && c < 15) m_code += 64;
                end
                m_state  = S_SETTLE;
                m_remain = SC;
            end
            S_FINE: if (freq_update) begin
                if (!freq_incr_decr) begin
                    if (m_code != CODE_MAX) m_code = (f == 63) ? (c + 1) * 64 + 32 : m_code + 1;
                end else begin
                    if (m_code != 0) m_code = (f == 0) ? (c - 1) * 64 + 31 : m_code - 1;
                end
                m_target = S_FINE;
                m_state  = S_SETTLE;
                m_remain = SC;
            end else if (fll_locked) begin
                m_state = S_TRACK;
            end
            S_SETTLE: begin
                m_remain--;
                if (m_remain == 0) m_state = m_target;
            end
            S_TRACK: if (!fll_locked) m_state = S_FINE;
            default: ;
        endcase
    endtask

    task automatic tick();
        @(posedge ref_clk);
        model_edge();
        #1;
        check("state",  32'(tune_state),  32'(m_state));
        check("sw",     32'(sw),          32'(sw_of(m_sw_code)));
        check("locked", 32'(tune_locked), 32'(m_state == S_TRACK));
        check("sat",    32'(code_sat),    32'(m_code == 0 || m_code == CODE_MAX));
    endtask

    task automatic pulse(input logic dir, input int gap);
        freq_update    = 1'b1;
        freq_incr_decr = dir;
        tick();
        freq_update = 1'b0;
        repeat (gap) tick();
    endtask

    initial begin
        int settle_n;
        model_reset();
        #23;
        check("rst_state",  32'(tune_state),  32'(S_IDLE));
        check("rst_sw",     32'(sw),          32'(SW_MID));
        check("rst_locked", 32'(tune_locked), 32'(0));
        check("rst_sat",    32'(code_sat),    32'(0));
        @(negedge ref_clk);
        reset  = 1'b1;
        enable = 1'b1;
        tick();

        // Coarse search: three lower-frequency steps, then a reversal into fine.
        repeat (3) pulse(1'b0, 19);
        check("coarse11", 32'(sw[20:6]), 32'(15'h07FF));
        pulse(1'b1, 19);
        check("enter_fine_state", 32'(tune_state), 32'(S_FINE));
        check("enter_fine_sw",    32'(sw), 32'({15'h07FF, 6'd32}));

        // Fine carry/borrow into coarse.
        repeat (31) pulse(1'b0, 16);
        check("fine63", 32'(sw), 32'({15'h07FF, 6'd63}));
        pulse(1'b0, 16);
        check("fine_carry", 32'(sw), 32'({15'h0FFF, 6'd32}));
        repeat (32) pulse(1'b1, 16);
        check("fine0", 32'(sw), 32'({15'h0FFF, 6'd0}));
        pulse(1'b1, 16);
        check("fine_borrow", 32'(sw), 32'({15'h07FF, 6'd31}));

        // Update dropped during settle; settle length.
        freq_update    = 1'b1;
        freq_incr_decr = 1'b0;
        tick();
        freq_update = 1'b0;
        settle_n = (tune_state == 3'(S_SETTLE)) ? 1 : 0;
        for (int i = 0; i < 40 && tune_state == 3'(S_SETTLE); i++) begin
            freq_update = (i == 4);
            tick();
            if (tune_state == 3'(S_SETTLE)) settle_n++;
        end
        freq_update = 1'b0;
        check("settle_len",  32'(settle_n), 32'(SC));
        check("settle_once", 32'(sw), 32'({15'h07FF, 6'd32}));

        // Lock tracking.
        fll_locked = 1'b1;
        tick();
        check("track_state",  32'(tune_state),  32'(S_TRACK));
        check("track_locked", 32'(tune_locked), 32'(1));
        pulse(1'b0, 2);
        check("track_hold", 32'(sw), 32'({15'h07FF, 6'd32}));
        fll_locked = 1'b0;
        tick();
        check("unlock_fine", 32'(tune_state), 32'(S_FINE));
        fll_locked = 1'b1;
        tick();
        enable = 1'b0;
        tick();
        check("dis_idle", 32'(tune_state), 32'(S_IDLE));
        check("dis_hold", 32'(sw), 32'({15'h07FF, 6'd32}));
        fll_locked = 1'b0;
        enable     = 1'b1;
        tick();

        // Drive to the top of the code range and saturate.
        repeat (5) pulse(1'b0, 16);
        check("coarse15", 32'(sw), 32'({15'h7FFF, 6'd32}));
        pulse(1'b1, 16);
        repeat (31) pulse(1'b0, 16);
        check("code_max_sat", 32'(code_sat), 32'(1));
        freq_update    = 1'b1;
        freq_incr_decr = 1'b0;
        tick();
        freq_update = 1'b0;
        check("sat_settle", 32'(tune_state), 32'(S_SETTLE));
        check("sat_hold",   32'(sw), 32'({15'h7FFF, 6'd63}));

        // Asynchronous reset in the middle of settle.
        repeat (3) tick();
        #2;
        reset = 1'b0;
        #1;
        check("async_state", 32'(tune_state), 32'(S_IDLE));
        check("async_sw",    32'(sw), 32'(SW_MID));
        check("async_sat",   32'(code_sat), 32'(0));
        model_reset();
        @(negedge ref_clk);
        reset = 1'b1;
        tick();

        // Randomized traffic against the model.
        for (int i = 0; i < 800; i++) begin
            enable         = ($urandom_range(0, 49) != 0);
            freq_update    = ($urandom_range(0, 5) == 0);
            freq_incr_decr = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) fll_locked = ~fll_locked;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
